// File: rtl/dpsk_demodulator.sv
// DPSK receive stage: integrate-and-dump per symbol, differential sign decode, MSB-first byte packing.
// Optional DPSK_DEMOD_SYNC_EN adds a HUNT/LOCK sync-word framer in front of the byte output.
module dpsk_demodulator #(
  parameter int          SAMPLE_W    = 16,
  parameter int          SPS         = 1,
  parameter logic [7:0]  SYNC_WORD   = 8'hD5,
  parameter int          FRAME_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_in_valid,
  input  logic signed [SAMPLE_W-1:0] i_in_sample,
  output logic                       o_bit_out,
  output logic                       o_bit_strobe,
  output logic [7:0]                 o_out_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic                       o_overrun,
  output logic                       o_locked
);

  localparam int ACC_W = SAMPLE_W + $clog2(SPS) + 1;
  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

  if (SPS < 1 || FRAME_BYTES < 1 || $bits(SYNC_WORD) != 8) begin : g_param_check
    $error("dpsk_demodulator: invalid parameters");
  end

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_prev_sign;
  logic             r_prev_data;
  logic             r_bit;
  logic             r_strobe;
  logic [6:0]       r_shift;
  logic [2:0]       r_bcnt;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_overrun;

  logic [ACC_W-1:0] w_sext;
  logic [ACC_W-1:0] w_sum;
  logic             w_last;
  logic             w_sign;
  logic             w_bit;
  logic [7:0]       w_shift_nxt;
  logic             w_pack;
  logic             w_complete;
  logic             w_xfer;

  assign w_sext = {{(ACC_W-SAMPLE_W){i_in_sample[SAMPLE_W-1]}}, i_in_sample};
  assign w_sum  = r_acc + w_sext;
  assign w_last = i_in_valid && (r_cnt == CNT_LAST);
  // A zero-sum symbol decodes as positive because only the MSB is inspected.
  assign w_sign = w_sum[ACC_W-1];
  assign w_bit  = r_prev_data ^ (w_sign ^ r_prev_sign);

  assign w_shift_nxt = {r_shift, r_bit};
  assign w_complete  = r_strobe && w_pack && (r_bcnt == 3'd7);
  assign w_xfer      = r_valid && i_out_ready;

`ifdef DPSK_DEMOD_SYNC_EN
  localparam int FCNT_W = $clog2(FRAME_BYTES + 1);

  typedef enum logic {HUNT, LOCK} state_t;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [FCNT_W-1:0] r_fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HUNT: if (r_strobe && (w_shift_nxt == SYNC_WORD)) w_state_nxt = LOCK;
      LOCK: if (w_complete && (r_fcnt == FCNT_W'(FRAME_BYTES - 1))) w_state_nxt = HUNT;
      default: w_state_nxt = HUNT;
    endcase
  end

  // Frame byte count includes dropped bytes; it idles at zero while hunting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_fcnt <= '0;
    else if (r_state == HUNT) r_fcnt <= '0;
    else if (w_complete)      r_fcnt <= r_fcnt + 1'b1;
  end

  assign w_pack   = (r_state == LOCK);
  assign o_locked = w_pack;
`else
  assign w_pack   = 1'b1;
  assign o_locked = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_prev_sign <= 1'b0;
      r_prev_data <= 1'b1;
      r_bit       <= 1'b0;
      r_strobe    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (i_in_valid) begin
        if (w_last) begin
          r_acc       <= '0;
          r_cnt       <= '0;
          r_prev_sign <= w_sign;
          r_prev_data <= w_bit;
          r_bit       <= w_bit;
          r_strobe    <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Bit counter is held at zero whenever packing is disabled, so lock starts a fresh byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bcnt  <= '0;
    end else if (r_strobe) begin
      r_shift <= w_shift_nxt[6:0];
      r_bcnt  <= w_pack ? r_bcnt + 1'b1 : 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_complete && (!r_valid || w_xfer)) begin
      r_data  <= w_shift_nxt;
      r_valid <= 1'b1;
    end else if (w_complete) begin
      r_overrun <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign o_bit_out    = r_bit;
  assign o_bit_strobe = r_strobe;
  assign o_out_data   = r_data;
  assign o_out_valid  = r_valid;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_dpsk_demodulator.sv
// Directed bench for dpsk_demodulator: SPS=1 instance for decode/packing/handshake,
// SPS=4 instance for integration width and mid-symbol reset.
module tb_dpsk_demodulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               v1, rdy1, b1, st1, ov1, or1, lk1;
  logic signed [15:0] s1;
  logic [7:0]         d1;
  logic               v4, rdy4, b4, st4, ov4, or4, lk4;
  logic signed [15:0] s4;
  logic [7:0]         d4;

  dpsk_demodulator #(.SAMPLE_W(16), .SPS(1)) dut (
    .clk(clk), .rst(rst), .i_in_valid(v1), .i_in_sample(s1),
    .o_bit_out(b1), .o_bit_strobe(st1), .o_out_data(d1), .o_out_valid(ov1),
    .i_out_ready(rdy1), .o_overrun(or1), .o_locked(lk1));

  dpsk_demodulator #(.SAMPLE_W(16), .SPS(4)) dut4 (
    .clk(clk), .rst(rst), .i_in_valid(v4), .i_in_sample(s4),
    .o_bit_out(b4), .o_bit_strobe(st4), .o_out_data(d4), .o_out_valid(ov4),
    .i_out_ready(rdy4), .o_overrun(or4), .o_locked(lk4));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send1(input logic signed [15:0] s);
    v1 = 1'b1; s1 = s;
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic send4(input logic signed [15:0] s);
    v4 = 1'b1; s4 = s;
    @(posedge clk); #1;
    v4 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
  endtask

  typedef struct {
    logic signed [15:0] s;
    logic               b;
  } vec_t;

  vec_t       tbl[16];
  logic [7:0] exp_byte[2];
  logic [7:0] tx_bytes[2];
  logic       pd, ps, bt;

  initial begin
    rst = 1'b1; v1 = 1'b0; s1 = '0; rdy1 = 1'b1; v4 = 1'b0; s4 = '0; rdy4 = 1'b1;
    #2;
    chk("rst_bit_out", b1, 0);
    chk("rst_strobe", st1, 0);
    chk("rst_out_data", d1, 0);
    chk("rst_out_valid", ov1, 0);
    chk("rst_overrun", or1, 0);
    chk("rst_locked", lk1, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // T1 / T2: constant +1000 then alternating -1000/+1000
    for (int i = 0; i < 8; i++) tbl[i] = '{16'sd1000, 1'b1};
    for (int i = 8; i < 16; i++)
      tbl[i] = (i % 2 == 0) ? '{-16'sd1000, 1'b0} : '{16'sd1000, 1'b1};
    exp_byte[0] = 8'hFF;
    exp_byte[1] = 8'h55;
    for (int i = 0; i < 16; i++) begin
      send1(tbl[i].s);
      chk($sformatf("vec%0d_strobe", i), st1, 1);
      chk($sformatf("vec%0d_bit", i), b1, tbl[i].b);
      if (i % 8 == 7) begin
        idle(1);
        chk($sformatf("vec%0d_byte_valid", i), ov1, 1);
        chk($sformatf("vec%0d_byte", i), d1, exp_byte[i/8]);
        chk($sformatf("vec%0d_strobe_low", i), st1, 0);
        idle(1);
        chk($sformatf("vec%0d_consumed", i), ov1, 0);
      end
    end

    // T3: loopback through a behavioural XNOR-differential modulator
    do_reset();
    tx_bytes[0] = 8'hA5;
    tx_bytes[1] = 8'h3C;
    pd = 1'b1; ps = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 7; j >= 0; j--) begin
        bt = tx_bytes[k][j];
        ps = ps ^ (bt ^ pd);
        pd = bt;
        send1(ps ? -16'sd1000 : 16'sd1000);
      end
      idle(1);
      chk($sformatf("loop_valid%0d", k), ov1, 1);
      chk($sformatf("loop_byte%0d", k), d1, tx_bytes[k]);
    end
    idle(1);
    chk("loop_overrun", or1, 0);

    // T4: SPS=4 zero-sum symbol and full-scale negative symbol
    do_reset();
    send4(16'sd3);
    chk("sps4_no_midstrobe", st4, 0);
    send4(-16'sd3); send4(16'sd2); send4(-16'sd2);
    chk("sps4_zero_strobe", st4, 1);
    chk("sps4_zero_bit", b4, 1);
    for (int i = 0; i < 4; i++) send4(16'sh8000);
    chk("sps4_neg_strobe", st4, 1);
    chk("sps4_neg_bit", b4, 0);
    send4(-16'sd1000); send4(-16'sd1000);
    do_reset();
    for (int i = 0; i < 4; i++) send4(16'sd3);
    chk("sps4_midsym_rst_bit", b4, 1);

    // T5: backpressure, simultaneous transfer+completion, overrun
    do_reset();
    rdy1 = 1'b0;
    for (int i = 0; i < 8; i++) send1(16'sd1000);
    idle(1);
    chk("bp_first_valid", ov1, 1);
    chk("bp_first_data", d1, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      send1(-16'sd1000);
      send1(16'sd1000);
    end
    rdy1 = 1'b1;
    idle(1);
    chk("simul_valid", ov1, 1);
    chk("simul_data", d1, 8'h55);
    chk("simul_no_overrun", or1, 0);
    rdy1 = 1'b0;
    idle(3);
    chk("hold_data", d1, 8'h55);
    for (int i = 0; i < 8; i++) send1(16'sd1000);
    idle(1);
    chk("ovr_flag", or1, 1);
    chk("ovr_data_kept", d1, 8'h55);
    chk("ovr_valid", ov1, 1);
    rdy1 = 1'b1;
    idle(1);
    chk("ovr_drain_valid", ov1, 0);
    chk("ovr_sticky", or1, 1);

    // T6: async reset after 5 bits of a byte
    for (int i = 0; i < 5; i++) send1(16'sd1000);
    chk("t6_bit_before_rst", b1, 1);
    rst = 1'b1;
    #2;
    chk("t6_rst_bit", b1, 0);
    chk("t6_rst_data", d1, 0);
    chk("t6_rst_overrun", or1, 0);
    chk("t6_rst_valid", ov1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      send1(16'sd1000);
      if (i == 2) begin
        idle(1);
        chk("t6_no_early_byte", ov1, 0);
      end
    end
    idle(1);
    chk("t6_byte_valid", ov1, 1);
    chk("t6_byte", d1, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
